// File: rtl/alu_stim_gen.sv
// Pseudo-random ALU transaction generator driven by a 32-bit Galois LFSR over a valid/ready handshake.
// Optional build macro ALU_STIM_CORNER_EN forces operands to all-ones on every 16th transaction.
module alu_stim_gen #(
  parameter int          DATA_W  = 8,
  parameter int          OP_W    = 3,
  parameter int          NUM_TXN = 10000,
  parameter logic [31:0] SEED    = 32'hACE1_2468,
  parameter int          CNT_W   = $clog2(NUM_TXN + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              seed_load,
  input  logic [31:0]       seed_in,
  output logic              txn_valid,
  input  logic              txn_ready,
  output logic [DATA_W-1:0] txn_a,
  output logic [DATA_W-1:0] txn_b,
  output logic [OP_W-1:0]   txn_op,
  output logic [CNT_W-1:0]  txn_idx,
  output logic              busy,
  output logic              done
);

  localparam logic [31:0]      POLY     = 32'h8020_0003;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_TXN - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      lfsr_q, lfsr_d;
  logic [31:0]      lfsr_step;
  logic [31:0]      seed_eff;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic             handshake;

  // A zero seed would lock the LFSR at zero, so it falls back to SEED.
  assign lfsr_step = (lfsr_q >> 1) ^ (lfsr_q[0] ? POLY : 32'h0);
  assign seed_eff  = (seed_in == 32'h0) ? SEED : seed_in;
  assign handshake = (state_q == ST_RUN) && txn_ready;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      lfsr_q  <= SEED;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      idx_q   <= idx_d;
    end
  end

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (seed_load) lfsr_d = seed_eff;
        if (start) begin
          state_d = ST_RUN;
          idx_d   = '0;
        end
      end
      ST_RUN: begin
        if (handshake) begin
          lfsr_d = lfsr_step;
          // The last index is held so the consumer can still read it in DONE.
          if (idx_q == LAST_IDX) state_d = ST_DONE;
          else                   idx_d   = idx_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign txn_valid = (state_q == ST_RUN);
  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign txn_idx   = idx_q;
  assign txn_op    = lfsr_q[2*DATA_W+OP_W-1:2*DATA_W];

`ifdef ALU_STIM_CORNER_EN
  logic [31:0] idx_ext;
  logic        corner_hit;

  // Operand forcing is purely on the output; the LFSR sequence is untouched.
  assign idx_ext    = 32'(idx_q);
  assign corner_hit = (idx_ext[3:0] == 4'hF);
  assign txn_a      = corner_hit ? {DATA_W{1'b1}} : lfsr_q[DATA_W-1:0];
  assign txn_b      = corner_hit ? {DATA_W{1'b1}} : lfsr_q[2*DATA_W-1:DATA_W];
`else
  assign txn_a      = lfsr_q[DATA_W-1:0];
  assign txn_b      = lfsr_q[2*DATA_W-1:DATA_W];
`endif

endmodule

// File: doc/alu_stim_gen.md
Name: alu_stim_gen

Overview:
- Hardware stimulus transmitter for the ALU datapath: generates a pseudo-random stream of ALU transactions (operand A, operand B, opcode) over a valid/ready handshake.
- Used for on-chip self-test of the ALU in the DDS calibration/ranging path. It is the driving end of the same transaction interface the ALU bench drives and monitors.
- Produces a fixed number of transactions per run, then signals done.

Parameters:
- DATA_W, 8, operand width; the constraint 2*DATA_W+OP_W <= 32 must hold.
- OP_W, 3, opcode width; all 2^OP_W codes are legal.
- NUM_TXN, 10000, transactions per run; must be >= 1.
- SEED, 32'hACE1_2468, LFSR value at reset and replacement for any zero seed; must be nonzero.
- CNT_W, $clog2(NUM_TXN+1), width of the transaction counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- start  in  1  begins a run when in IDLE or DONE.
- seed_load  in  1  loads seed_in into the LFSR when in IDLE or DONE.
- seed_in  in  32  seed value; a value of 0 is replaced by SEED.
- txn_valid  out  1  transaction fields are valid.
- txn_ready  in  1  consumer accepts the transaction.
- txn_a  out  DATA_W  operand A.
- txn_b  out  DATA_W  operand B.
- txn_op  out  OP_W  opcode.
- txn_idx  out  CNT_W  index of the current transaction, 0-based.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, lfsr=SEED, txn_idx=0, txn_valid=0, busy=0, done=0. This applies in any state, including mid-run; an in-flight transaction is dropped.
- LFSR: 32-bit Galois shift-right. next = (lfsr>>1) ^ (lfsr[0] ? 32'h8020_0003 : 32'h0). It never reaches 0.
- Field mapping (combinational from lfsr): txn_a=lfsr[DATA_W-1:0], txn_b=lfsr[2*DATA_W-1:DATA_W], txn_op=lfsr[2*DATA_W+OP_W-1:2*DATA_W].
- FSM states: IDLE, RUN, DONE.
  - IDLE/DONE to RUN: on start=1. txn_idx cleared to 0. txn_valid=1 from the next cycle.
  - The LFSR is not re-seeded by start. A new run continues the sequence unless seed_load is used.
  - seed_load and start in the same cycle: the seed is loaded and the run starts. The first transaction uses the loaded seed.
  - RUN: txn_valid=1 continuously.
    - Handshake occurs on txn_valid & txn_ready at a clk edge. The LFSR advances once and txn_idx increments.
    - While txn_ready=0, lfsr, txn_idx and all txn_* fields hold stable (no advance, no change).
  - RUN to DONE: on the handshake where txn_idx==NUM_TXN-1. txn_valid drops the next cycle. txn_idx holds NUM_TXN-1.
  - DONE: done=1, held until start or reset.
- start and seed_load are ignored in RUN.
- Throughput: one transaction per cycle when txn_ready is held high. No bubbles between transactions.
- Latency: start at edge N gives txn_valid=1 after edge N. The first fields equal the current lfsr.
- NUM_TXN=1: the first handshake goes directly to DONE.

Optional Feature:
- ALU_STIM_CORNER_EN defined: when txn_idx[3:0]==4'hF, txn_a and txn_b are forced to all-ones. txn_op still comes from the LFSR, and the LFSR advances normally, so the sequence is unaffected.
- Undefined: no forcing; fields always come from the LFSR.

Test Plan:
- Reset, then seed_load=1 with seed_in=32'h1 and start=1 together, txn_ready=1 -> txn0: a=8'h01, b=8'h00, op=3'd0; txn1: a=8'h03, b=8'h00, op=3'd0 (lfsr=32'h8020_0003); txn_idx=0 then 1.
- Backpressure: txn_ready=0 for 5 cycles mid-run -> txn_valid stays 1; txn_a/b/op and txn_idx unchanged; after ready=1, the sequence resumes with no skipped LFSR step.
- Full run with NUM_TXN=10000 and ready=1 -> exactly 10000 handshakes; done=1 on the cycle after the last; txn_valid=0, busy=0.
- seed_in=0 loaded -> first txn uses SEED: a=8'h68, b=8'h24, op=3'd1 (from 32'hACE1_2468).
- Reset (rst_n=0) asserted at txn_idx=37 -> next cycle state=IDLE, txn_valid=0, lfsr=SEED, txn_idx=0; start in RUN is ignored.
- With ALU_STIM_CORNER_EN defined -> txn_idx 15 and 31 show a=b=8'hFF; txn_idx 16 matches the run without the macro.
